// File: rtl/axi_confreg_slave.sv
// -----------------------------------------------------------------------------
// axi_confreg_slave
//   AXI responder for the uncached configuration-register window. The arbiter
//   has already routed on the base address, so only offset bits [4:2] are
//   decoded here. One transaction runs at a time: either an INCR read burst of
//   up to 16 beats, or a single-beat write.
//
//   Register map (word index = addr[4:2]):
//     0 scratch0 RW   1 scratch1 RW   2 led RW (upper bits read 0)
//     3 switch RO     4 timer RW      5 ID RO (CONF_ID)   6,7 read 0
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   ar*/r*                     read address / read data channels
//   aw*/w*/b*                  write address / data / response channels
//   led                        LED register (low LED_W bits of index 2)
//   sw                         raw switch input, double-flop synchronised here
// -----------------------------------------------------------------------------
module axi_confreg_slave #(
    parameter logic [31:0] CONF_ID = 32'h2023_0001,
    parameter int          LED_W   = 16,
    parameter int          SW_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    // read address
    input  logic [31:0]      araddr,
    input  logic [7:0]       arlen,
    input  logic [2:0]       arsize,
    input  logic             arvalid,
    output logic             arready,
    // read data
    output logic [31:0]      rdata,
    output logic [1:0]       rresp,
    output logic             rlast,
    output logic             rvalid,
    input  logic             rready,
    // write address
    input  logic [31:0]      awaddr,
    input  logic             awvalid,
    output logic             awready,
    // write data
    input  logic [31:0]      wdata,
    input  logic [3:0]       wstrb,
    input  logic             wlast,
    input  logic             wvalid,
    output logic             wready,
    // write response
    output logic [1:0]       bresp,
    output logic             bvalid,
    input  logic             bready,
    // board I/O
    output logic [LED_W-1:0] led,
    input  logic [SW_W-1:0]  sw
);

    typedef enum logic [1:0] {IDLE, RDATA, WDATA, WRESP} state_t;

    state_t            state, state_nxt;

    logic [31:0]       scratch0, scratch1, timer;
    logic [LED_W-1:0]  led_q;
    logic [SW_W-1:0]   sw_meta, sw_sync;

    logic [2:0]        rd_idx;      // index of the next beat to register
    logic [3:0]        rd_cnt;      // beats remaining after the one on the bus
    logic [2:0]        wr_idx;

    logic [2:0]        rd_sel;
    logic [31:0]       rd_word;
    logic [31:0]       wr_old, wr_merged;
    logic              ar_hs, r_hs, wr_en;

    // Address width, burst type/size and wlast carry no information here.
    logic              unused;
    assign unused = ^{araddr[31:5], araddr[1:0], arlen[7:4], arsize,
                      awaddr[31:5], awaddr[1:0], wlast};

    assign rresp = 2'b00;
    assign bresp = 2'b00;
    assign led   = led_q;

    assign ar_hs = arvalid & arready;
    assign r_hs  = rvalid & rready;
    assign wr_en = (state == WDATA) & wvalid;

    // -------------------------------------------------------------------------
    // FSM: next state and handshake outputs. The address readies are gated
    // with rst_n so they drop the moment reset asserts.
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        arready   = 1'b0;
        awready   = 1'b0;
        wready    = 1'b0;
        bvalid    = 1'b0;
        case (state)
            IDLE: begin
                awready = rst_n;
                arready = rst_n & ~awvalid;   // write wins a same-cycle tie
                if (awvalid)      state_nxt = WDATA;
                else if (arvalid) state_nxt = RDATA;
            end
            RDATA: begin
                if (r_hs && rlast) state_nxt = IDLE;
            end
            WDATA: begin
                wready = 1'b1;
                if (wvalid) state_nxt = WRESP;
            end
            WRESP: begin
                bvalid = 1'b1;
                if (bready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // -------------------------------------------------------------------------
    // Read mux. In IDLE it serves the first beat straight from araddr; during
    // a burst it serves the following index.
    // -------------------------------------------------------------------------
    always_comb begin
        rd_sel  = (state == IDLE) ? araddr[4:2] : rd_idx;
        rd_word = 32'h0;
        case (rd_sel)
            3'd0:    rd_word = scratch0;
            3'd1:    rd_word = scratch1;
            3'd2:    rd_word = 32'(led_q);
            3'd3:    rd_word = 32'(sw_sync);
            3'd4:    rd_word = timer;
            3'd5:    rd_word = CONF_ID;
            default: rd_word = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid <= 1'b0;
            rlast  <= 1'b0;
            rdata  <= 32'h0;
            rd_idx <= 3'd0;
            rd_cnt <= 4'd0;
        end else if (state == IDLE && ar_hs) begin
            rvalid <= 1'b1;
            rdata  <= rd_word;
            rd_idx <= araddr[4:2] + 3'd1;     // wraps 7 -> 0
            rd_cnt <= arlen[3:0];
            rlast  <= (arlen[3:0] == 4'd0);
        end else if (state == RDATA && r_hs) begin
            if (rlast) begin
                rvalid <= 1'b0;
                rlast  <= 1'b0;
            end else begin
                rdata  <= rd_word;
                rd_idx <= rd_idx + 3'd1;
                rd_cnt <= rd_cnt - 4'd1;
                rlast  <= (rd_cnt == 4'd1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Write path: byte-merge wdata over the current register value. The timer
    // merges over its pre-increment value.
    // -------------------------------------------------------------------------
    always_comb begin
        wr_old = 32'h0;
        case (wr_idx)
            3'd0:    wr_old = scratch0;
            3'd1:    wr_old = scratch1;
            3'd2:    wr_old = 32'(led_q);
            3'd4:    wr_old = timer;
            default: wr_old = 32'h0;
        endcase
        wr_merged = wr_old;
        for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) wr_merged[8*i +: 8] = wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx   <= 3'd0;
            scratch0 <= 32'h0;
            scratch1 <= 32'h0;
            led_q    <= '0;
            timer    <= 32'h0;
        end else begin
            if (state == IDLE && awvalid) wr_idx <= awaddr[4:2];
            if (wr_en && wr_idx == 3'd0) scratch0 <= wr_merged;
            if (wr_en && wr_idx == 3'd1) scratch1 <= wr_merged;
            if (wr_en && wr_idx == 3'd2) led_q    <= wr_merged[LED_W-1:0];
            if (wr_en && wr_idx == 3'd4) timer    <= wr_merged;
            else                         timer    <= timer + 32'd1;
        end
    end

    // Switch synchroniser.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
        end
    end

endmodule

// File: tb/tb_axi_confreg_slave.sv
// -----------------------------------------------------------------------------
// tb_axi_confreg_slave
//   Directed stimulus against axi_confreg_slave. A transaction-level model
//   (register array, cycle-counting timer, sw pipeline, expected beat) is
//   updated on each clock edge from observed handshakes and checked against
//   the DUT every cycle; directed tests add hand-computed literal checks.
// -----------------------------------------------------------------------------
module tb_axi_confreg_slave;

    localparam logic [31:0] CONF_ID = 32'h2023_0001;
    localparam int          LED_W   = 16;
    localparam int          SW_W    = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [31:0]      araddr, awaddr, wdata, rdata;
    logic [7:0]       arlen;
    logic [2:0]       arsize;
    logic             arvalid, arready, rlast, rvalid, rready;
    logic             awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [1:0]       rresp, bresp;
    logic [3:0]       wstrb;
    logic [LED_W-1:0] led;
    logic [SW_W-1:0]  sw;

    always #5 clk = ~clk;

    axi_confreg_slave #(.CONF_ID(CONF_ID), .LED_W(LED_W), .SW_W(SW_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .led(led), .sw(sw)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- cycle counter and beat log ----------------
    int          cyc = 0;
    int          hs_total = 0;
    logic [31:0] data_log [0:1023];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rst_n && rvalid && rready) begin
            data_log[hs_total[9:0]] <= rdata;
            hs_total <= hs_total + 1;
        end
    end

    // ---------------- behavioural model ----------------
    logic [31:0]      m_s0, m_s1, m_tmr, m_rdata;
    logic [LED_W-1:0] m_led;
    logic [SW_W-1:0]  m_sw1, m_sw2;
    logic             m_rv, m_rlast;
    logic [2:0]       m_ridx, m_widx;
    int               m_rem, m_wph;   // m_wph: 0 idle, 1 wait W, 2 wait B

    function automatic logic [31:0] mread(input logic [2:0] i);
        case (i)
            3'd0:    return m_s0;
            3'd1:    return m_s1;
            3'd2:    return 32'(m_led);
            3'd3:    return 32'(m_sw2);
            3'd4:    return m_tmr;
            3'd5:    return CONF_ID;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? n[8*b +: 8] : o[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s0 <= 0; m_s1 <= 0; m_tmr <= 0; m_rdata <= 0; m_led <= 0;
            m_sw1 <= 0; m_sw2 <= 0; m_rv <= 0; m_rlast <= 0;
            m_ridx <= 0; m_widx <= 0; m_rem <= 0; m_wph <= 0;
        end else begin : upd
            logic [31:0] t, lw;
            t = m_tmr + 1;
            if (!m_rv && m_wph == 0 && arvalid && !awvalid) begin
                m_rv    <= 1'b1;
                m_rdata <= mread(araddr[4:2]);
                m_ridx  <= araddr[4:2] + 3'd1;
                m_rem   <= int'(arlen[3:0]);
                m_rlast <= (arlen[3:0] == 4'd0);
            end else if (m_rv && rready) begin
                if (m_rlast) m_rv <= 1'b0;
                else begin
                    m_rdata <= mread(m_ridx);
                    m_ridx  <= m_ridx + 3'd1;
                    m_rem   <= m_rem - 1;
                    m_rlast <= (m_rem == 1);
                end
            end
            if (m_wph == 0 && !m_rv && awvalid) begin
                m_wph  <= 1;
                m_widx <= awaddr[4:2];
            end else if (m_wph == 1 && wvalid) begin
                m_wph <= 2;
                case (m_widx)
                    3'd0: m_s0 <= merge(m_s0, wdata, wstrb);
                    3'd1: m_s1 <= merge(m_s1, wdata, wstrb);
                    3'd2: begin lw = merge(32'(m_led), wdata, wstrb); m_led <= lw[LED_W-1:0]; end
                    3'd4: t = merge(m_tmr, wdata, wstrb);
                    default: ;
                endcase
            end else if (m_wph == 2 && bready) begin
                m_wph <= 0;
            end
            m_tmr <= t;
            m_sw1 <= sw;
            m_sw2 <= m_sw1;
        end
    end

    // ---------------- per-cycle compare ----------------
    always begin
        @(negedge clk);
        #2;
        begin
            logic idle;
            idle = rst_n && !m_rv && m_wph == 0;
            chk("awready", awready, idle);
            chk("arready", arready, idle && !awvalid);
            chk("wready",  wready,  m_wph == 1);
            chk("bvalid",  bvalid,  m_wph == 2);
            chk("rvalid",  rvalid,  m_rv);
            chk("led",     led,     m_led);
            chk("resp",    {rresp, bresp}, 4'h0);
            if (m_rv) begin
                chk("rdata", rdata, m_rdata);
                chk("rlast", rlast, m_rlast);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    int last_hs_cyc;

    // which: 0 awready, 1 wready, 2 bvalid, 3 arready
    task automatic wait_hs(input int which, input string nm);
        bit ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(posedge clk);
            case (which)
                0: ok = awready;
                1: ok = wready;
                2: ok = bvalid;
                default: ok = arready;
            endcase
        end
        last_hs_cyc = cyc;
        if (!ok) begin
            n_chk++; n_err++;
            $display("FAIL timeout %s: no handshake within 50 cycles", nm);
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        awaddr = a; awvalid = 1; wdata = d; wstrb = s; wvalid = 1; wlast = 1;
        wait_hs(0, "aw");
        @(negedge clk); awvalid = 0;
        wait_hs(1, "w");
        @(negedge clk); wvalid = 0;
        wait_hs(2, "b");
        @(negedge clk);
    endtask

    // Issues a burst; bp = cycles rready is held low once the first beat shows.
    task automatic do_read(input logic [31:0] a, input logic [3:0] len, input int bp,
                           output int base);
        bit done = 0;
        base = hs_total;
        @(negedge clk);
        araddr = a; arlen = {4'h0, len}; arvalid = 1; rready = (bp == 0);
        wait_hs(3, "ar");
        @(negedge clk); arvalid = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            if (rvalid && bp > 0) begin bp--; rready = 0; end
            else rready = 1;
            @(negedge clk);
            done = (hs_total >= base + int'(len) + 1);
        end
        rready = 1;
        chk("beat_count", 32'(hs_total - base), 32'(int'(len) + 1));
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int b, tw, ta;
        rst_n = 0; araddr = 0; arlen = 0; arsize = 3'd2; arvalid = 0; rready = 1;
        awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wlast = 0; wvalid = 0;
        bready = 1; sw = 0;

        // reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_rvalid",  rvalid,  0);
        chk("rst_bvalid",  bvalid,  0);
        chk("rst_arready", arready, 0);
        chk("rst_awready", awready, 0);
        chk("rst_rdata",   rdata,   0);
        @(negedge clk); rst_n = 1;

        // scratch0 write/read
        do_write(32'h00, 32'hCAFE_F00D, 4'hF);
        do_read(32'h00, 4'd0, 0, b);
        chk("s0_read", data_log[b], 32'hCAFE_F00D);

        // reset mid-burst
        @(negedge clk);
        araddr = 32'h00; arlen = 8'd3; arvalid = 1; rready = 0;
        wait_hs(3, "ar_rst");
        @(negedge clk); arvalid = 0;
        chk("mid_rvalid_hi", rvalid, 1);
        rst_n = 0;
        #1;
        chk("mid_rvalid",  rvalid,  0);
        chk("mid_rlast",   rlast,   0);
        chk("mid_arready", arready, 0);
        chk("mid_awready", awready, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1; rready = 1;
        do_read(32'h00, 4'd0, 0, b);
        chk("s0_after_rst", data_log[b], 32'h0);

        // scratch1 partial write
        do_write(32'h04, 32'h1122_3344, 4'hF);
        do_write(32'h04, 32'hDEAD_BEEF, 4'b0101);
        do_read(32'h04, 4'd0, 0, b);
        chk("s1_merge", data_log[b], 32'h11AD_33EF);

        // wrapping burst from ID
        do_write(32'h00, 32'h5A5A_0001, 4'hF);
        do_read(32'h14, 4'd3, 0, b);
        chk("wrap_b0", data_log[b],     CONF_ID);
        chk("wrap_b1", data_log[b + 1], 32'h0);
        chk("wrap_b2", data_log[b + 2], 32'h0);
        chk("wrap_b3", data_log[b + 3], 32'h5A5A_0001);

        // backpressure
        do_read(32'h00, 4'd1, 3, b);
        chk("bp_b0", data_log[b],     32'h5A5A_0001);
        chk("bp_b1", data_log[b + 1], 32'h11AD_33EF);

        // tie: write to timer wins, read of timer follows
        b = hs_total;
        @(negedge clk);
        araddr = 32'h10; arlen = 8'd0; arvalid = 1;
        awaddr = 32'h10; awvalid = 1; wdata = 32'h100; wstrb = 4'hF; wvalid = 1; wlast = 1;
        #1;
        chk("tie_arready", arready, 0);
        chk("tie_awready", awready, 1);
        wait_hs(0, "aw_tie");
        @(negedge clk); awvalid = 0;
        wait_hs(1, "w_tie"); tw = last_hs_cyc;
        @(negedge clk); wvalid = 0;
        wait_hs(2, "b_tie");
        wait_hs(3, "ar_tie"); ta = last_hs_cyc;
        @(negedge clk); arvalid = 0;
        for (int i = 0; i < 20 && hs_total == b; i++) @(negedge clk);
        // timer holds 0x100 after the write edge, +1 each later edge; the beat
        // captures the pre-edge value at the ar edge
        chk("timer_read", data_log[b], 32'h100 + 32'(ta - tw - 1));

        // LED
        do_write(32'h08, 32'hFFFF_A5A5, 4'hF);
        chk("led_port", led, 16'hA5A5);
        do_read(32'h08, 4'd0, 0, b);
        chk("led_read", data_log[b], 32'h0000_A5A5);

        // switch
        @(negedge clk); sw = 16'h00F0;
        repeat (3) @(negedge clk);
        do_read(32'h0C, 4'd0, 0, b);
        chk("sw_read", data_log[b], 32'h0000_00F0);

        // RO and unmapped writes are ignored
        do_write(32'h14, 32'hFFFF_FFFF, 4'hF);
        do_write(32'h1C, 32'h1234_5678, 4'hF);
        do_read(32'h14, 4'd3, 0, b);
        chk("id_ro",   data_log[b],     CONF_ID);
        chk("idx7_ro", data_log[b + 2], 32'h0);
        chk("wrap_s0", data_log[b + 3], 32'h5A5A_0001);

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
